// File: rtl/conv_fprop1_udiv_62ns_31ns_31_seq.sv
// Sequential restoring radix-2 unsigned divider, 62/31 -> 31 quotient + 31 remainder.
// One quotient bit per enabled cycle, valid/ready on both sides, ce freezes all state.
module conv_fprop1_udiv_62ns_31ns_31_seq #(
    parameter int ID             = 1,
    parameter int DIVIDEND_WIDTH = 62,
    parameter int DIVISOR_WIDTH  = 31,
    parameter int QUOT_WIDTH     = 31
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [QUOT_WIDTH-1:0]     quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div_by_zero,
    output logic                      overflow
);

    localparam int CNT_W = $clog2(QUOT_WIDTH);

    if (QUOT_WIDTH != DIVIDEND_WIDTH - DIVISOR_WIDTH || ID < 0) begin : g_param_check
        $error("quotient width must equal dividend width minus divisor width");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic [DIVISOR_WIDTH-1:0] part_rem;
    logic [QUOT_WIDTH-1:0]    shreg;
    logic [DIVISOR_WIDTH-1:0] dvsr;

    logic [DIVISOR_WIDTH-1:0] dividend_hi;
    logic                     zero_div;
    logic                     too_big;
    logic                     last_step;
    logic [DIVISOR_WIDTH:0]   trial;
    logic                     fits;
    logic [DIVISOR_WIDTH-1:0] step_rem;
    logic [QUOT_WIDTH-1:0]    step_q;

    assign dividend_hi = dividend[DIVIDEND_WIDTH-1:QUOT_WIDTH];
    assign zero_div    = (divisor == '0);
    assign too_big     = (dividend_hi >= divisor);
    assign last_step   = (cnt == CNT_W'(QUOT_WIDTH - 1));

    // Partial remainder stays below the divisor, so the difference always fits in DIVISOR_WIDTH bits.
    assign trial    = {part_rem, shreg[QUOT_WIDTH-1]};
    assign fits     = (trial >= {1'b0, dvsr});
    assign step_rem = fits ? (trial[DIVISOR_WIDTH-1:0] - dvsr) : trial[DIVISOR_WIDTH-1:0];
    assign step_q   = {shreg[QUOT_WIDTH-2:0], fits};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = (zero_div || too_big) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            part_rem    <= '0;
            shreg       <= '0;
            dvsr        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (ce) begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvsr <= divisor;
                        cnt  <= '0;
                        if (zero_div) begin
                            quotient    <= '1;
                            remainder   <= dividend[DIVISOR_WIDTH-1:0];
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b1;
                        end else if (too_big) begin
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                        end else begin
                            part_rem <= dividend_hi;
                            shreg    <= dividend[QUOT_WIDTH-1:0];
                        end
                    end
                end
                CALC: begin
                    part_rem <= step_rem;
                    shreg    <= step_q;
                    cnt      <= cnt + 1'b1;
                    if (last_step) begin
                        quotient    <= step_q;
                        remainder   <= step_rem;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
